div_sequencer: RTL and testbench

DIV_SEQUENCER -- requirements
Module: div_sequencer

---
 rtl/muldiv_pkg.sv | 24 ++
 rtl/div_special.sv | 40 ++++
 rtl/div_sequencer.sv | 131 +++++++++++++
 tb/tb_div_sequencer.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the divide sequencer slice.
//   - funct3 encodings of the four divide/remainder ops
//   - sequencer state encoding
//   - timeout bound for the iterative core
package muldiv_pkg;

  localparam logic [2:0] OP_DIV  = 3'b100;
  localparam logic [2:0] OP_DIVU = 3'b101;
  localparam logic [2:0] OP_REM  = 3'b110;
  localparam logic [2:0] OP_REMU = 3'b111;

  // Cycles allowed in WAIT_HI/WAIT_LO before the op is abandoned.
  localparam logic [5:0] TIMEOUT_LIMIT = 6'd40;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LAUNCH  = 3'd1,
    WAIT_HI = 3'd2,
    WAIT_LO = 3'd3,
    RESP    = 3'd4,
    DRAIN   = 3'd5
  } state_t;

endpackage

// File: rtl/div_special.sv
// div_special: combinational detection of divide ops whose result is
// architecturally fixed and need no trip through the iterative core.
//   op    : funct3 (bit2 = divide group, bit1 = remainder, bit0 = unsigned)
//   rs1   : dividend
//   rs2   : divisor
//   hit   : op is a special case
//   value : result for the special case (0 when hit is low)
module div_special
  import muldiv_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        hit,
  output logic [31:0] value
);

  logic is_rem;
  logic is_signed;

  assign is_rem    = op[1];
  assign is_signed = ~op[0];

  always_comb begin
    hit   = 1'b0;
    value = '0;
    if (op[2]) begin
      if (rs2 == '0) begin
        // Divide by zero: quotient all ones, remainder is the dividend.
        hit   = 1'b1;
        value = is_rem ? rs1 : '1;
      end else if (is_signed && rs1 == 32'h8000_0000 && rs2 == '1) begin
        // Signed overflow: quotient wraps to the dividend, remainder 0.
        hit   = 1'b1;
        value = is_rem ? '0 : 32'h8000_0000;
      end
    end
  end

endmodule

// File: rtl/div_sequencer.sv
// div_sequencer: hands divide/remainder ops from execute to an external
// iterative divider core and returns the result to writeback.
//   clk, rst_n              : clock, async active-low reset
//   req_valid/ready/op/rs1/rs2/rd : op request from execute
//   flush                   : kills the in-flight op (no response)
//   core_start              : one-cycle launch pulse to the core
//   core_op/num/den         : operands held to the core
//   core_busy, core_result  : core status and result
//   rsp_valid/ready/data/rd : result handshake to writeback
//   timeout                 : sticky, core exceeded TIMEOUT_LIMIT cycles
module div_sequencer
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  input  logic [4:0]  req_rd,
  input  logic        flush,
  output logic        core_start,
  output logic [2:0]  core_op,
  output logic [31:0] core_num,
  output logic [31:0] core_den,
  input  logic        core_busy,
  input  logic [31:0] core_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [4:0]  rsp_rd,
  output logic        timeout
);

  state_t      state;
  logic [2:0]  op_q;
  logic [31:0] num_q;
  logic [31:0] den_q;
  logic [4:0]  rd_q;
  logic [31:0] data_q;
  logic [5:0]  cnt_q;
  logic [5:0]  cnt_inc;
  logic        timeout_q;
  logic        accept;
  logic        sp_hit;
  logic [31:0] sp_value;

  // Special cases are judged on the incoming operands so the result is
  // ready on the cycle right after accept.
  div_special u_special (
    .op    (req_op),
    .rs1   (req_rs1),
    .rs2   (req_rs2),
    .hit   (sp_hit),
    .value (sp_value)
  );

  // A flush in IDLE must block the accept, so it also drops ready.
  assign req_ready = (state == IDLE) && !core_busy && !flush;
  assign accept    = req_valid && req_ready;

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 6'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_q      <= '0;
      num_q     <= '0;
      den_q     <= '0;
      rd_q      <= '0;
      data_q    <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q  <= req_op;
            num_q <= req_rs1;
            den_q <= req_rs2;
            rd_q  <= req_rd;
            if (sp_hit) begin
              data_q <= sp_value;
              state  <= RESP;
            end else begin
              state <= LAUNCH;
            end
          end
        end
        LAUNCH: begin
          cnt_q <= '0;
          state <= flush ? DRAIN : WAIT_HI;
        end
        WAIT_HI, WAIT_LO: begin
          if (flush) begin
            state <= DRAIN;
          end else if (state == WAIT_LO && !core_busy) begin
            data_q <= core_result;
            state  <= RESP;
          end else if (cnt_inc == TIMEOUT_LIMIT) begin
            timeout_q <= 1'b1;
            data_q    <= '0;
            state     <= RESP;
          end else begin
            cnt_q <= cnt_inc;
            if (state == WAIT_HI && core_busy) state <= WAIT_LO;
          end
        end
        RESP: begin
          // Flush and rsp_ready both end the response; flush wins.
          if (flush || rsp_ready) state <= IDLE;
        end
        DRAIN: begin
          if (!core_busy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign core_start = (state == LAUNCH);
  assign core_op    = op_q;
  assign core_num   = num_q;
  assign core_den   = den_q;
  assign rsp_valid  = (state == RESP);
  assign rsp_data   = data_q;
  assign rsp_rd     = rd_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_div_sequencer.sv
module tb_div_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid, req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_rs1, req_rs2;
  logic [4:0]  req_rd;
  logic        flush;
  logic        core_start;
  logic [2:0]  core_op;
  logic [31:0] core_num, core_den;
  logic        core_busy;
  logic [31:0] core_result;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_rd;
  logic        timeout;

  logic core_busy_m = 1'b0;
  logic busy_force  = 1'b0;
  assign core_busy = core_busy_m | busy_force;

  int iter      = 4;
  bit no_core   = 1'b0;
  int start_cnt = 0;
  int total     = 0;
  int bad       = 0;

  always #5 clk = ~clk;

  div_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
    .flush(flush),
    .core_start(core_start), .core_op(core_op), .core_num(core_num), .core_den(core_den),
    .core_busy(core_busy), .core_result(core_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_rd(rsp_rd),
    .timeout(timeout)
  );

  // Behavioural iterative core: busy for 'iter' cycles after each start.
  initial begin
    core_result = '0;
    forever begin
      @(negedge clk);
      if (core_start) begin
        start_cnt++;
        if (!no_core) begin
          case (core_op)
            3'b100:  core_result = $signed(core_num) / $signed(core_den);
            3'b101:  core_result = core_num / core_den;
            3'b110:  core_result = $signed(core_num) % $signed(core_den);
            default: core_result = core_num % core_den;
          endcase
          core_busy_m = 1'b1;
          repeat (iter) @(negedge clk);
          core_busy_m = 1'b0;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Present an op and return just after its accept edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, output bit ok);
    req_op = op; req_rs1 = a; req_rs2 = b; req_rd = rd; req_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 80 && !ok; i++) begin
      @(negedge clk); #1;
      if (req_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int bound, output int cyc, output bit ok);
    cyc = 0;
    ok  = rsp_valid;
    while (!ok && cyc < bound) begin
      @(posedge clk); #1;
      cyc++;
      ok = rsp_valid;
    end
  endtask

  task automatic consume;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    tick(2);
    total++;
    if ({rsp_valid, core_start, timeout, rsp_data, rsp_rd, core_op, core_num, core_den} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got v=%b s=%b t=%b d=%h rd=%h op=%h n=%h den=%h want all zero",
               rsp_valid, core_start, timeout, rsp_data, rsp_rd, core_op, core_num, core_den);
    end
    rst_n = 1'b1;
    tick(1);
    @(negedge clk); #1;
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    bit          spec;
  } vec_t;

  task automatic test_ops;
    vec_t vt[13];
    bit ok, ok2;
    int cyc, s0;
    vt[0]  = '{3'b100, 32'd100,        32'd7,          5'd5,  32'd14,         1'b0};
    vt[1]  = '{3'b110, 32'hFFFF_FF9C,  32'd7,          5'd9,  32'hFFFF_FFFE,  1'b0};
    vt[2]  = '{3'b100, 32'hFFFF_FF9C,  32'd7,          5'd10, 32'hFFFF_FFF2,  1'b0};
    vt[3]  = '{3'b101, 32'hFFFF_FFF0,  32'd3,          5'd17, 32'h5555_5550,  1'b0};
    vt[4]  = '{3'b111, 32'hFFFF_FFF0,  32'd7,          5'd31, 32'd2,          1'b0};
    vt[5]  = '{3'b101, 32'd5,          32'd0,          5'd3,  32'hFFFF_FFFF,  1'b1};
    vt[6]  = '{3'b111, 32'd5,          32'd0,          5'd4,  32'd5,          1'b1};
    vt[7]  = '{3'b100, 32'h1234_5678,  32'd0,          5'd8,  32'hFFFF_FFFF,  1'b1};
    vt[8]  = '{3'b110, 32'h1234_5678,  32'd0,          5'd11, 32'h1234_5678,  1'b1};
    vt[9]  = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  5'd12, 32'h8000_0000,  1'b1};
    vt[10] = '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  5'd13, 32'd0,          1'b1};
    vt[11] = '{3'b101, 32'h8000_0000,  32'hFFFF_FFFF,  5'd14, 32'd0,          1'b0};
    vt[12] = '{3'b111, 32'h8000_0000,  32'hFFFF_FFFF,  5'd15, 32'h8000_0000,  1'b0};
    for (int i = 0; i < 13; i++) begin
      s0 = start_cnt;
      issue(vt[i].op, vt[i].a, vt[i].b, vt[i].rd, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL ops_accept[%0d]: got no accept want accept", i); end
      wait_rsp(30, cyc, ok2);
      total++;
      if (!ok2 || cyc != (vt[i].spec ? 0 : 5)) begin
        bad++;
        $display("FAIL ops_latency[%0d]: got valid=%b after %0d cycles want %0d", i, ok2, cyc, vt[i].spec ? 0 : 5);
      end
      total++;
      if (rsp_data !== vt[i].exp) begin
        bad++; $display("FAIL ops_data[%0d]: got %h want %h", i, rsp_data, vt[i].exp);
      end
      total++;
      if (rsp_rd !== vt[i].rd) begin
        bad++; $display("FAIL ops_rd[%0d]: got %0d want %0d", i, rsp_rd, vt[i].rd);
      end
      total++;
      if (start_cnt - s0 != (vt[i].spec ? 0 : 1)) begin
        bad++; $display("FAIL ops_starts[%0d]: got %0d want %0d", i, start_cnt - s0, vt[i].spec ? 0 : 1);
      end
      total++;
      if ({core_op, core_num, core_den} !== {vt[i].op, vt[i].a, vt[i].b}) begin
        bad++; $display("FAIL ops_hold[%0d]: got %h/%h/%h want %h/%h/%h", i, core_op, core_num, core_den,
                        vt[i].op, vt[i].a, vt[i].b);
      end
      consume();
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    int cyc;
    issue(3'b100, 32'd100, 32'd7, 5'd5, ok);
    wait_rsp(30, cyc, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL bp_rsp: got no rsp_valid want rsp_valid"); end
    req_op = 3'b111; req_rs1 = 32'd5; req_rs2 = 32'd0; req_rd = 5'd12; req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      total++;
      if ({rsp_valid, rsp_data, rsp_rd, req_ready} !== {1'b1, 32'd14, 5'd5, 1'b0}) begin
        bad++;
        $display("FAIL bp_hold[%0d]: got v=%b d=%h rd=%0d rdy=%b want v=1 d=0000000e rd=5 rdy=0",
                 i, rsp_valid, rsp_data, rsp_rd, req_ready);
      end
      @(posedge clk); #1;
    end
    consume();
    @(negedge clk); #1;
    total++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      bad++; $display("FAIL b2b_gap: got v=%b rdy=%b want v=0 rdy=1", rsp_valid, req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    total++;
    if ({rsp_valid, rsp_data, rsp_rd} !== {1'b1, 32'd5, 5'd12}) begin
      bad++; $display("FAIL b2b_second: got v=%b d=%h rd=%0d want v=1 d=00000005 rd=12", rsp_valid, rsp_data, rsp_rd);
    end
    consume();
  endtask

  task automatic test_flush;
    bit ok, fell;
    int cyc;
    iter = 8;
    issue(3'b100, 32'd1000, 32'd10, 5'd2, ok);
    tick(2);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    fell = 1'b0;
    for (int i = 0; i < 20 && !fell; i++) begin
      @(negedge clk); #1;
      if (!core_busy) fell = 1'b1;
      else begin
        total++;
        if ({rsp_valid, req_ready} !== 2'b00) begin
          bad++; $display("FAIL flush_drain[%0d]: got v=%b rdy=%b want v=0 rdy=0", i, rsp_valid, req_ready);
        end
      end
    end
    total++;
    if (!fell) begin bad++; $display("FAIL flush_busy: got busy stuck want busy fall"); end
    iter = 4;
    tick(2);
    total++;
    if (rsp_valid !== 1'b0) begin bad++; $display("FAIL flush_norsp: got %b want 0", rsp_valid); end
    issue(3'b101, 32'd1000, 32'd10, 5'd3, ok);
    wait_rsp(30, cyc, ok);
    total++;
    if ({ok, rsp_data, rsp_rd} !== {1'b1, 32'd100, 5'd3}) begin
      bad++; $display("FAIL flush_next: got v=%b d=%h rd=%0d want v=1 d=00000064 rd=3", ok, rsp_data, rsp_rd);
    end
    consume();
    // Flush in RESP together with rsp_ready.
    issue(3'b111, 32'd5, 32'd0, 5'd4, ok);
    flush = 1'b1; rsp_ready = 1'b1;
    tick(1);
    flush = 1'b0; rsp_ready = 1'b0;
    total++;
    if (rsp_valid !== 1'b0) begin bad++; $display("FAIL flush_resp: got %b want 0", rsp_valid); end
    // Flush in IDLE blocks the accept.
    req_op = 3'b101; req_rs1 = 32'd7; req_rs2 = 32'd0; req_rd = 5'd1; req_valid = 1'b1; flush = 1'b1;
    @(negedge clk); #1;
    total++;
    if (req_ready !== 1'b0) begin bad++; $display("FAIL flush_idle_ready: got %b want 0", req_ready); end
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0;
    total++;
    if ({rsp_valid, core_start, core_num} !== {1'b0, 1'b0, 32'd5}) begin
      bad++; $display("FAIL flush_idle_accept: got v=%b s=%b num=%h want v=0 s=0 num=00000005",
                      rsp_valid, core_start, core_num);
    end
    tick(1);
  endtask

  task automatic test_reset_midflight;
    bit ok, fell;
    int cyc;
    iter = 12;
    issue(3'b100, 32'd100, 32'd7, 5'd5, ok);
    tick(2);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({rsp_valid, core_start, timeout, rsp_data, rsp_rd, core_op, core_num, core_den} !== '0) begin
      bad++;
      $display("FAIL rst_async: got v=%b s=%b t=%b d=%h rd=%h op=%h n=%h den=%h want all zero",
               rsp_valid, core_start, timeout, rsp_data, rsp_rd, core_op, core_num, core_den);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    fell = 1'b0;
    for (int i = 0; i < 20 && !fell; i++) begin
      @(negedge clk); #1;
      if (!core_busy) fell = 1'b1;
      else begin
        total++;
        if (req_ready !== 1'b0) begin bad++; $display("FAIL rst_ready[%0d]: got %b want 0", i, req_ready); end
      end
    end
    total++;
    if (!fell) begin bad++; $display("FAIL rst_busy: got busy stuck want busy fall"); end
    iter = 4;
    @(posedge clk); #1;
    issue(3'b100, 32'd100, 32'd7, 5'd6, ok);
    wait_rsp(30, cyc, ok);
    total++;
    if ({ok, cyc, rsp_data, rsp_rd} !== {1'b1, 32'd5, 32'd14, 5'd6}) begin
      bad++; $display("FAIL rst_next: got v=%b cyc=%0d d=%h rd=%0d want v=1 cyc=5 d=0000000e rd=6",
                      ok, cyc, rsp_data, rsp_rd);
    end
    consume();
  endtask

  task automatic test_timeout;
    bit ok;
    int cyc;
    total++;
    if (timeout !== 1'b0) begin bad++; $display("FAIL to_initial: got %b want 0", timeout); end
    no_core = 1'b1;
    issue(3'b100, 32'd100, 32'd7, 5'd7, ok);
    busy_force = 1'b1;
    wait_rsp(60, cyc, ok);
    total++;
    if (!ok || cyc != 41) begin
      bad++; $display("FAIL to_latency: got valid=%b after %0d cycles want 41", ok, cyc);
    end
    total++;
    if ({timeout, rsp_data, rsp_rd} !== {1'b1, 32'd0, 5'd7}) begin
      bad++; $display("FAIL to_result: got t=%b d=%h rd=%0d want t=1 d=00000000 rd=7", timeout, rsp_data, rsp_rd);
    end
    consume();
    @(negedge clk); #1;
    total++;
    if (req_ready !== 1'b0) begin bad++; $display("FAIL to_busy_ready: got %b want 0", req_ready); end
    busy_force = 1'b0;
    no_core = 1'b0;
    @(negedge clk); #1;
    total++;
    if ({timeout, req_ready} !== 2'b11) begin
      bad++; $display("FAIL to_sticky: got t=%b rdy=%b want t=1 rdy=1", timeout, req_ready);
    end
    tick(1);
  endtask

  initial begin
    req_valid = 1'b0; req_op = '0; req_rs1 = '0; req_rs2 = '0; req_rd = '0;
    flush = 1'b0; rsp_ready = 1'b0;
    test_reset();
    test_ops();
    test_back_to_back();
    test_flush();
    test_reset_midflight();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
